// File: rtl/div.sv
// rtl/div.sv - 32-bit multicycle restoring divider (DIV/DIVU), result {HI=remainder, LO=quotient}.
// Optional feature macro: DIV_BY_ZERO_DETECT_EN (early zero result for a zero divisor).
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE,
        ON,
        END
`ifdef DIV_BY_ZERO_DETECT_EN
        , BYZERO
`endif
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] div_temp;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op1_mag  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    assign div_temp = {1'b0, work[63:32]} - {1'b0, divisor};
    // Quotient bits shift in at the bottom; the partial remainder lives in the top 32 bits.
    assign quot     = work[31:0];
    assign rem      = work[64:33];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
`ifdef DIV_BY_ZERO_DETECT_EN
                        if (opdata2_i == 32'd0) state <= BYZERO; else
`endif
                        begin
                            // Sign flags are captured here so later operand changes cannot matter.
                            work    <= {32'd0, op1_mag, 1'b0};
                            divisor <= op2_mag;
                            neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r   <= signed_div_i && opdata1_i[31];
                            cnt     <= 6'd0;
                            state   <= ON;
                        end
                    end
                end
`ifdef DIV_BY_ZERO_DETECT_EN
                BYZERO: begin
                    if (annul_i || !start_i) begin
                        state <= FREE;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= 64'd0;
                        state    <= END;
                    end
                end
`endif
                ON: begin
                    if (annul_i || !start_i) begin
                        cnt   <= 6'd0;
                        state <= FREE;
                    end else if (cnt == 6'd32) begin
                        result_o[63:32] <= neg_r ? (~rem + 32'd1) : rem;
                        result_o[31:0]  <= neg_q ? (~quot + 32'd1) : quot;
                        ready_o         <= 1'b1;
                        cnt             <= 6'd0;
                        state           <= END;
                    end else begin
                        if (div_temp[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {div_temp[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                        state    <= FREE;
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div: directed cases plus randomized divides vs. arithmetic model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic (truncating division, remainder follows dividend).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
`ifdef DIV_BY_ZERO_DETECT_EN
            return 64'd0;
`else
            return {a, ((sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF)};
`endif
        end
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_BY_ZERO_DETECT_EN
        if (b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input int hold, input string tag);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        exp       = ref_div(a, b, sgn);
        exp_lat   = ref_lat(b);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = sgn;
        start_i   = 1'b1;
        lat       = 0;
        do begin
            step();
            lat++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sgn;
            if (lat == 5 && exp_lat == 34)
                check64({tag, "_busy"}, {ready_o, result_o}, 65'd0);
        end while (!ready_o && lat < 100);
        check64({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check64({tag, "_res"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check64({tag, "_hold"}, {ready_o, result_o}, {1'b1, exp});
        end
        start_i = 1'b0;
        step();
        check64({tag, "_drop"}, {ready_o, result_o}, 65'd0);
    endtask

    task automatic expect_idle(input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (ready_o) seen = 1'b1;
        end
        check64(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) step();
        check64("reset", {ready_o, result_o}, 65'd0);

        rst = 1'b0;
        run_div(32'd100, 32'd7, 1'b0, 5, "u100_7");
        check64("u100_7_const", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 2, "s_m7_2");
        run_div(32'd5, 32'd0, 1'b0, 2, "u5_0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2, "s_min_m1");
        run_div(32'hFFFF_FFF7, 32'd0, 1'b1, 1, "s_m9_0");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1, "s_7_m2");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1, "u_max_1");

        // Annul mid-divide: no result, then a fresh request completes normally.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        signed_div_i = 1'b0;
        start_i   = 1'b1;
        repeat (9) step();
        annul_i = 1'b1;
        step();
        check64("annul_out", {ready_o, result_o}, 65'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        expect_idle(40, "annul_noready");
        run_div(32'd9, 32'd3, 1'b0, 1, "u9_3");

        // Reset at edge 20 of a divide aborts it without a ready pulse.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (19) step();
        rst = 1'b1;
        step();
        check64("rst_mid", {ready_o, result_o}, 65'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        expect_idle(40, "rst_noready");
        run_div(32'd100, 32'd7, 1'b0, 1, "u100_7_again");

        for (int n = 0; n < 20; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            if (sgn && $urandom_range(0, 1) == 1) b = -b;
            run_div(a, b, sgn, 1, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port signed_div_i, input, 1 bit: 1 = signed divide (DIV), 0 = unsigned (DIVU).
REQ-004 The block SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-005 The block SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-006 The block SHALL have port start_i, input, 1 bit: request from the EX stage, held high until the result is consumed.
REQ-007 The block SHALL have port annul_i, input, 1 bit: cancel the in-flight divide (pipeline flush).
REQ-008 The block SHALL have port result_o, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 The block SHALL have port ready_o, output, 1 bit: result_o valid.

Function
REQ-010 The block SHALL implement four states: FREE, BYZERO, ON and END; FREE is the reset state.
REQ-011 In FREE, if start_i=1 and annul_i=0 and the divisor is 0, the block SHALL go to BYZERO; otherwise, if start_i=1 and annul_i=0, it SHALL latch the operands, clear the 6-bit iteration counter cnt and go to ON; in every other case it SHALL stay in FREE.
REQ-012 On latch in signed mode, each negative operand SHALL be converted to its two's-complement magnitude; in unsigned mode the operands SHALL be used as-is.
REQ-013 ON SHALL perform one restoring shift-subtract step per clock on a 65-bit working register, using a 33-bit trial subtraction, and SHALL increment cnt.
REQ-014 When cnt==32 in ON, the block SHALL apply the sign fix-ups, register the result and go to END; the divide therefore takes 32 iteration edges.
REQ-015 Signed fix-up: the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-016 Latency: counting the edge that samples start_i as edge 1, ready_o SHALL go high after edge 34 for a normal divide and after edge 2 for a BYZERO divide.
REQ-017 BYZERO SHALL set result_o=0 and go to END after one cycle.
REQ-018 END SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-019 When start_i=0 in END, the block SHALL clear ready_o and result_o on the next edge and return to FREE.
REQ-020 In ON or BYZERO, annul_i=1 or start_i=0 SHALL return the block to FREE on the next edge, with ready_o=0 and result_o=0 and no result produced.
REQ-021 A new request SHALL be accepted only from FREE; start_i held high through END SHALL NOT retrigger a divide.
REQ-022 ready_o SHALL be 0 in FREE, BYZERO and ON, and result_o SHALL be 0 whenever ready_o=0.
REQ-023 Operand changes after latch SHALL NOT affect the in-flight divide.
REQ-024 The boundary case 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0 (wraps, no trap).

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL go to FREE with cnt=0, the working register=0, ready_o=0 and result_o=0.
REQ-026 Reset SHALL take priority over all inputs in every state, including mid-divide; the aborted divide SHALL produce no result and no ready_o pulse.
REQ-027 The first request SHALL be accepted on the first edge with rst=0 and start_i=1.

Configuration
REQ-028 The feature macro SHALL be named DIV_BY_ZERO_DETECT_EN.
REQ-029 With DIV_BY_ZERO_DETECT_EN defined, a zero divisor SHALL take the BYZERO path (REQ-016, REQ-017: result 0, ready after edge 2).
REQ-030 Without DIV_BY_ZERO_DETECT_EN, BYZERO SHALL NOT exist; a zero divisor SHALL run the full 32 iterations and return the raw algorithm output with signed fix-ups applied; unsigned n/0 SHALL give quotient 0xFFFFFFFF and remainder n.

Verification
REQ-031 Unsigned 100/7, start held -> ready_o rises after edge 34; result_o = 0x00000002_0000000E.
REQ-032 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD.
REQ-033 Unsigned 5/0 -> with DIV_BY_ZERO_DETECT_EN: ready_o after edge 2, result_o = 0; without it: ready_o after edge 34, result_o = 0x00000005_FFFFFFFF.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> result_o = 0x00000000_80000000.
REQ-035 annul_i=1 at edge 10 of a 100/7 divide -> FREE, ready_o never asserts; a new 9/3 request then gives 0x00000000_00000003.
REQ-036 rst=1 at edge 20 mid-divide -> all outputs 0, state FREE; start_i held through END for 5 cycles -> result_o stable, no retrigger; start_i drop -> ready_o=0 next edge.
